// File: rtl/rf_writeback_pkg.sv
// Shared constants for the register-file write-back slice: datapath widths,
// register count and the load-queue entry width ({rd, data}).
package rf_writeback_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM        = 32;
  localparam int LQ_ENTRY_W     = REG_ADDR_WIDTH + CPU_WIDTH;

endpackage

// File: rtl/rf_writeback_if.sv
// Bundle of execute/load/scoreboard/issue/register-file signals around the
// write-back stage; master is the pipeline side, slave is rf_writeback.
interface rf_wb_if
  import rf_writeback_pkg::*;
#(
  parameter int DATA_W = CPU_WIDTH,
  parameter int ADDR_W = REG_ADDR_WIDTH
) ();

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;

  logic              sb_set;
  logic [ADDR_W-1:0] sb_set_addr;

  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rs1_fwd_hit;
  logic              rs2_fwd_hit;
  logic [DATA_W-1:0] rs1_fwd_data;
  logic [DATA_W-1:0] rs2_fwd_data;

  logic              reg_wen;
  logic [ADDR_W-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;

  modport master (
    output ex_valid, ex_rd, ex_data,
    output ld_valid, ld_rd, ld_data,
    output sb_set, sb_set_addr,
    output rs1_addr, rs2_addr,
    input  ld_ready,
    input  rs1_busy, rs2_busy, rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data, rs2_fwd_data,
    input  reg_wen, reg_waddr, reg_wdata
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data,
    input  ld_valid, ld_rd, ld_data,
    input  sb_set, sb_set_addr,
    input  rs1_addr, rs2_addr,
    output ld_ready,
    output rs1_busy, rs2_busy, rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data, rs2_fwd_data,
    output reg_wen, reg_waddr, reg_wdata
  );

endinterface

// File: rtl/rf_writeback_lq.sv
// rf_wb_lq: synchronous FIFO holding load results until the write port is free.
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_lq
  import rf_writeback_pkg::*;
#(
  parameter int WIDTH = LQ_ENTRY_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/rf_writeback.sv
// Write-back stage: arbitrates execute vs. queued load results onto the register
// file port, keeps the load scoreboard. Define RF_WB_FWD_EN to enable forwarding.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int DATA_W   = CPU_WIDTH,
  parameter int ADDR_W   = REG_ADDR_WIDTH,
  parameter int LQ_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  rf_wb_if.slave wb
);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic              lq_push, lq_pop, lq_full, lq_empty;
  logic [ENT_W-1:0]  lq_head;
  logic [CNT_W-1:0]  lq_count;
  logic [ADDR_W-1:0] lq_head_rd;
  logic [DATA_W-1:0] lq_head_data;

  logic              reg_wen_q, reg_wen_d;
  logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [REG_NUM-1:0] sb_q, sb_d;

  assign lq_push      = wb.ld_valid && !lq_full;
  assign lq_pop       = !wb.ex_valid && !lq_empty;
  assign lq_head_rd   = lq_head[DATA_W +: ADDR_W];
  assign lq_head_data = lq_head[DATA_W-1:0];

  rf_wb_lq #(
    .WIDTH (ENT_W),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lq_push),
    .push_data ({wb.ld_rd, wb.ld_data}),
    .pop       (lq_pop),
    .pop_data  (lq_head),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  assign wb.ld_ready = (lq_count < CNT_W'(LQ_DEPTH));

  // Execute has strict priority; a load only moves when the port is idle.
  always_comb begin
    reg_wen_d   = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    if (wb.ex_valid) begin
      reg_wen_d   = (wb.ex_rd != '0);
      reg_waddr_d = wb.ex_rd;
      reg_wdata_d = wb.ex_data;
    end else if (lq_pop) begin
      reg_wen_d   = (lq_head_rd != '0);
      reg_waddr_d = lq_head_rd;
      reg_wdata_d = lq_head_data;
    end
  end

  // Set is applied after clear so a re-dispatch in the retiring cycle survives.
  always_comb begin
    sb_d = sb_q;
    if (lq_pop)    sb_d[lq_head_rd]     = 1'b0;
    if (wb.sb_set) sb_d[wb.sb_set_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_wen_q   <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      sb_q        <= '0;
    end else begin
      reg_wen_q   <= reg_wen_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      sb_q        <= sb_d;
    end
  end

  assign wb.reg_wen   = reg_wen_q;
  assign wb.reg_waddr = reg_waddr_q;
  assign wb.reg_wdata = reg_wdata_q;

  function automatic logic out_match(input logic [ADDR_W-1:0] a);
    return reg_wen_q && (reg_waddr_q == a) && (a != '0);
  endfunction

`ifdef RF_WB_FWD_EN
  assign wb.rs1_busy     = sb_q[wb.rs1_addr];
  assign wb.rs2_busy     = sb_q[wb.rs2_addr];
  assign wb.rs1_fwd_hit  = out_match(wb.rs1_addr);
  assign wb.rs2_fwd_hit  = out_match(wb.rs2_addr);
  assign wb.rs1_fwd_data = reg_wdata_q;
  assign wb.rs2_fwd_data = reg_wdata_q;
`else
  // Without a bypass the issue stage waits one extra cycle for the write to land.
  assign wb.rs1_busy     = sb_q[wb.rs1_addr] | out_match(wb.rs1_addr);
  assign wb.rs2_busy     = sb_q[wb.rs2_addr] | out_match(wb.rs2_addr);
  assign wb.rs1_fwd_hit  = 1'b0;
  assign wb.rs2_fwd_hit  = 1'b0;
  assign wb.rs1_fwd_data = '0;
  assign wb.rs2_fwd_data = '0;
`endif

`ifndef SYNTHESIS
  a_ex_waw: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb.ex_valid && sb_q[wb.ex_rd]))
    else $error("rf_writeback: execute write to register with pending load");

  // Re-dispatch onto the register retiring this very cycle is not a double booking.
  a_sb_double: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb.sb_set && sb_q[wb.sb_set_addr] && !(lq_pop && lq_head_rd == wb.sb_set_addr)))
    else $error("rf_writeback: scoreboard set on busy register");

  a_ld_unbooked: assert property (@(posedge clk) disable iff (!rst_n)
    !(lq_pop && lq_head_rd != '0 && !sb_q[lq_head_rd]))
    else $error("rf_writeback: load result for register not marked busy");
`endif

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-back stage directly upstream of the integer register file (x0..x31).
- Merges two result sources onto the single register-file write port:
  - single-cycle execute results;
  - multi-cycle load results, buffered in a small queue.
- Keeps a load scoreboard and supplies forwarding data for the write held in its output register, so the issue stage can detect RAW hazards.

Parameters:
- DATA_W, 32, data width; equals CPU_WIDTH.
- ADDR_W, 5, register address width; equals REG_ADDR_WIDTH.
- LQ_DEPTH, 2, load-result queue depth; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  execute result valid; always accepted, no ready
- ex_rd  in  ADDR_W  execute destination register
- ex_data  in  DATA_W  execute result
- ld_valid  in  1  load result valid
- ld_ready  out  1  load queue can accept a result
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data (already aligned and extended)
- sb_set  in  1  issue stage dispatched a load
- sb_set_addr  in  ADDR_W  destination of the dispatched load
- rs1_addr, rs2_addr  in  ADDR_W  issue-stage source addresses
- rs1_busy, rs2_busy  out  1  source has a pending write; issue stage stalls
- rs1_fwd_hit, rs2_fwd_hit  out  1  output register holds the write for this source
- rs1_fwd_data, rs2_fwd_data  out  DATA_W  forwarded value
- reg_wen  out  1  register-file write enable
- reg_waddr  out  ADDR_W  register-file write address
- reg_wdata  out  DATA_W  register-file write data

Behaviour:
- Reset (clk edge with rst_n=0):
  - reg_wen=0, reg_waddr=0, reg_wdata=0;
  - load queue emptied;
  - scoreboard cleared to all zeros.
  - Reset asserted mid-operation discards queued loads and pending busy bits.
- Load queue:
  - FIFO of LQ_DEPTH {rd, data} entries.
  - Push when ld_valid && ld_ready.
  - ld_ready = (count < LQ_DEPTH); depends on count only, with no same-cycle pop look-ahead.
  - Pointers wrap modulo LQ_DEPTH.
- Output-register arbitration, evaluated each cycle:
  - ex_valid=1: output register loads {ex_rd, ex_data}. Execute always wins.
  - else queue non-empty: pop the head into the output register.
  - else reg_wen<=0.
  - The registered reg_wen is 1 only when the selected rd != 0.
- Latency:
  - Execute: presented in cycle N, reg_wen=1 in cycle N+1, register file updated at the end of N+1.
  - Load: at least 1 cycle in the queue plus 1 cycle in the output register; more if execute keeps winning. No starvation guarantee is required.
- Scoreboard (one busy bit per register, bit 0 hard-wired to 0):
  - sb_set with a nonzero address sets the bit.
  - A load popped into the output register clears its rd bit in the same edge.
  - Set and clear of the same address in one cycle: set wins.
  - rsN_busy = scoreboard[rsN_addr]; address 0 always reports not busy.
- Forwarding:
  - rsN_fwd_hit = reg_wen && reg_waddr == rsN_addr && rsN_addr != 0.
  - rsN_fwd_data = reg_wdata.
- Illegal conditions, flagged with simulation-only assertions; hardware behaviour undefined:
  - ex_valid with a busy ex_rd (WAW hazard);
  - sb_set on an already-busy address;
  - a queued ld_rd whose scoreboard bit is clear.

Optional Feature:
- RF_WB_FWD_EN defined:
  - fwd ports behave as described above;
  - rsN_busy reflects the scoreboard only.
- RF_WB_FWD_EN undefined:
  - rsN_fwd_hit=0 and rsN_fwd_data=0 constantly;
  - rsN_busy is additionally asserted when reg_wen && reg_waddr == rsN_addr (nonzero), so the issue stage stalls one cycle instead of forwarding.

Decomposition:
- Shared package/defines: DATA_W/ADDR_W from CPU_WIDTH/REG_ADDR_WIDTH; a queue-entry width constant (ADDR_W+DATA_W); REG_NUM=32.
- One natural sub-module: rf_wb_lq, the parameterised synchronous FIFO (push/pop/count/full/empty). Arbitration, scoreboard and forwarding stay in the top module.

Test Plan:
- Reset, then ex_valid with rd=5, data=0x12345678 → next cycle reg_wen=1, waddr=5, wdata=0x12345678; the cycle after, reg_wen=0.
- ex_valid with rd=0, data=0xFFFFFFFF → reg_wen stays 0; rs1_addr=0 gives busy=0 and fwd_hit=0.
- sb_set addr=7; rs1_addr=7 → rs1_busy=1. Load rd=7, data=0xA5A5A5A5 pushed with no ex traffic → busy clears 2 cycles after the push; write lands that cycle; with RF_WB_FWD_EN, rs1_fwd_hit=1 and fwd_data=0xA5A5A5A5 in that cycle.
- Three back-to-back loads (rd 1,2,3) while ex_valid stays high for 4 cycles (rd 10..13):
  - ld_ready drops after 2 pushes;
  - execute writes 10..13 in order;
  - then loads 1,2 drain, third accepted when space frees;
  - all write in FIFO order.
- sb_set addr=9 in the same cycle a load rd=9 pops → bit 9 remains set.
- rst_n=0 for one edge with 2 queued loads → queue empty, all busy bits 0, reg_wen=0, queued data never written.
